// File: rtl/seq_rec_pkg.sv
// Shared constants for the serial pattern recogniser and its status helpers.
package seq_rec_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

endpackage : seq_rec_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/seq_pattern_rec_mealy.sv
// Mealy recogniser for a programmable, maskable serial bit pattern with
// overlapping / non-overlapping modes and a saturating hit counter.
module seq_pattern_rec_mealy
    import seq_rec_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_in,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
    input  logic             clr,
    output logic             d_out,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_pattern_rec_mealy: PAT_W out of range");
    end
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("seq_pattern_rec_mealy: CNT_W out of range");
    end

    logic [HIST_W-1:0] hist_q,     hist_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [PAT_W-1:0]  cfg_pat_q,  cfg_pat_d;
    logic [PAT_W-1:0]  cfg_mask_q, cfg_mask_d;
    logic              cfg_ovl_q,  cfg_ovl_d;

    logic [PAT_W-1:0]  window_c;
    logic              match_c;
    logic              ovl_c;

    // Oldest bit sits in the MSB so the window lines up with pat directly.
    assign window_c = {hist_q, d_in};
    assign ovl_c    = (cfg_ovl_q == MODE_OVL);
    assign match_c  = en && (fill_q == FILL_FULL)
                      && (((window_c ^ cfg_pat_q) & cfg_mask_q) == '0);

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        cfg_pat_d  = cfg_pat_q;
        cfg_mask_d = cfg_mask_q;
        cfg_ovl_d  = cfg_ovl_q;
        if (en) begin
            hist_d = HIST_W'({hist_q, d_in});
            if (match_c && !ovl_c) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end else begin
            // Idle: flush history and track the live configuration inputs.
            hist_d     = '0;
            fill_d     = '0;
            cfg_pat_d  = pat;
            cfg_mask_d = mask;
            cfg_ovl_d  = overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q     <= '0;
            fill_q     <= '0;
            cfg_pat_q  <= '0;
            cfg_mask_q <= '0;
            cfg_ovl_q  <= MODE_NONOVL;
        end else begin
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            cfg_pat_q  <= cfg_pat_d;
            cfg_mask_q <= cfg_mask_d;
            cfg_ovl_q  <= cfg_ovl_d;
        end
    end

    assign d_out = match_c;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (match_c),
        .cnt   (hit_cnt)
    );

endmodule : seq_pattern_rec_mealy

// File: tb/tb_seq_pattern_rec_mealy.sv
// Scoreboard bench: two recogniser instances (PAT_W=4/CNT_W=8, PAT_W=3/CNT_W=2)
// checked every cycle against a window-based reference model.
module tb_seq_pattern_rec_mealy;

    localparam int AW  = 4;
    localparam int ACW = 8;
    localparam int BW  = 3;
    localparam int BCW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           a_en, a_d, a_ovl, a_clr, a_dout;
    logic [AW-1:0]  a_pat, a_mask;
    logic [ACW-1:0] a_cnt;
    logic           b_en, b_d, b_ovl, b_clr, b_dout;
    logic [BW-1:0]  b_pat, b_mask;
    logic [BCW-1:0] b_cnt;

    seq_pattern_rec_mealy #(.PAT_W(AW), .CNT_W(ACW)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .d_in(a_d), .pat(a_pat), .mask(a_mask),
        .overlap(a_ovl), .clr(a_clr), .d_out(a_dout), .hit_cnt(a_cnt)
    );

    seq_pattern_rec_mealy #(.PAT_W(BW), .CNT_W(BCW)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .d_in(b_d), .pat(b_pat), .mask(b_mask),
        .overlap(b_ovl), .clr(b_clr), .d_out(b_dout), .hit_cnt(b_cnt)
    );

    typedef struct packed {
        logic        d;
        logic [31:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference model: a window of the bits seen since the last flush.
    int unsigned m_pat[2], m_mask[2], m_win[2], m_cnt[2];
    int          m_seen[2];
    bit          m_ovl[2];

    // Staged stimulus, applied just after each rising edge.
    bit          s_rst_n;
    bit          s_en[2], s_d[2], s_clr[2], s_ovl[2];
    int unsigned s_pat[2], s_mask[2];

    task automatic model_step(input int id, input int pw, input int cw, input bit rn,
                              input bit en, input bit d, input bit clr,
                              input int unsigned pat, input int unsigned mask,
                              input bit ovl, output exp_t e);
        int unsigned w;
        int unsigned maxc;
        bit          match;
        maxc  = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
        e.cnt = m_cnt[id];
        match = 1'b0;
        if (en && (m_seen[id] >= pw - 1)) begin
            w     = (m_win[id] << 1) | 32'(d);
            match = 1'b1;
            for (int k = 0; k < pw; k++) begin
                if (m_mask[id][k] && (w[k] != m_pat[id][k])) match = 1'b0;
            end
        end
        e.d = match;
        if (!rn) begin
            m_pat[id] = 0; m_mask[id] = 0; m_ovl[id] = 1'b0;
            m_win[id] = 0; m_seen[id] = 0; m_cnt[id] = 0;
        end else begin
            if (!en) begin
                m_pat[id]  = pat;
                m_mask[id] = mask;
                m_ovl[id]  = ovl;
                m_win[id]  = 0;
                m_seen[id] = 0;
            end else begin
                m_win[id]  = (m_win[id] << 1) | 32'(d);
                m_seen[id] = m_seen[id] + 1;
                if (match && !m_ovl[id]) m_seen[id] = 0;
            end
            if (clr) m_cnt[id] = 0;
            else if (match && (m_cnt[id] != maxc)) m_cnt[id] = m_cnt[id] + 1;
        end
    endtask

    task automatic tick();
        exp_t ea, eb;
        @(posedge clk);
        #2;
        rst_n  = s_rst_n;
        a_en   = s_en[0];  a_d = s_d[0];  a_clr = s_clr[0];  a_ovl = s_ovl[0];
        a_pat  = AW'(s_pat[0]);  a_mask = AW'(s_mask[0]);
        b_en   = s_en[1];  b_d = s_d[1];  b_clr = s_clr[1];  b_ovl = s_ovl[1];
        b_pat  = BW'(s_pat[1]);  b_mask = BW'(s_mask[1]);
        model_step(0, AW, ACW, s_rst_n, s_en[0], s_d[0], s_clr[0],
                   s_pat[0] & 32'hF, s_mask[0] & 32'hF, s_ovl[0], ea);
        model_step(1, BW, BCW, s_rst_n, s_en[1], s_d[1], s_clr[1],
                   s_pat[1] & 32'h7, s_mask[1] & 32'h7, s_ovl[1], eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Idle both instances except id, then load config and clear its counter.
    task automatic set_cfg(input int id, input int unsigned pat, input int unsigned mask,
                           input bit ovl);
        for (int i = 0; i < 2; i++) begin
            s_en[i] = 1'b0; s_clr[i] = 1'b0; s_d[i] = 1'b0;
        end
        s_pat[id] = pat; s_mask[id] = mask; s_ovl[id] = ovl; s_clr[id] = 1'b1;
        tick();
        s_clr[id] = 1'b0;
    endtask

    task automatic bits(input int id, input int unsigned v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            s_en[id] = 1'b1;
            s_d[id]  = v[i];
            tick();
        end
    endtask

    task automatic idle(input int id);
        s_en[id] = 1'b0; s_d[id] = 1'b0; s_clr[id] = 1'b0;
        tick();
    endtask

    // Monitor: every cycle both DUTs present d_out and hit_cnt.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            n_vec++;
            if (a_dout !== e.d || a_cnt !== ACW'(e.cnt)) begin
                n_miss++;
                $display("FAIL dut_a t=%0t: d_out=%0b hit_cnt=%0d, expected d_out=%0b hit_cnt=%0d",
                         $time, a_dout, a_cnt, e.d, e.cnt);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            n_vec++;
            if (b_dout !== e.d || b_cnt !== BCW'(e.cnt)) begin
                n_miss++;
                $display("FAIL dut_b t=%0t: d_out=%0b hit_cnt=%0d, expected d_out=%0b hit_cnt=%0d",
                         $time, b_dout, b_cnt, e.d, e.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_d = 1'b0; a_clr = 1'b0; a_ovl = 1'b0; a_pat = '0; a_mask = '0;
        b_en = 1'b0; b_d = 1'b0; b_clr = 1'b0; b_ovl = 1'b0; b_pat = '0; b_mask = '0;
        for (int i = 0; i < 2; i++) begin
            m_pat[i] = 0; m_mask[i] = 0; m_win[i] = 0; m_cnt[i] = 0; m_seen[i] = 0;
            m_ovl[i] = 1'b0;
            s_en[i] = 1'b0; s_d[i] = 1'b0; s_clr[i] = 1'b0; s_ovl[i] = 1'b0;
            s_pat[i] = 0; s_mask[i] = 0;
        end
        s_rst_n = 1'b0;
        tick();
        tick();
        chk("reset_cnt_a", 32'(a_cnt), 0);
        chk("reset_cnt_b", 32'(b_cnt), 0);
        s_rst_n = 1'b1;

        // Legacy three-ones, overlapping: hits on bits 4, 5, 9.
        set_cfg(1, 3'b111, 3'b111, 1'b1);
        bits(1, 9'b011110111, 9);
        idle(1);
        chk("legacy_ovl_cnt", 32'(b_cnt), 3);

        // Non-overlapping: seven ones hit on bits 3 and 6.
        set_cfg(1, 3'b111, 3'b111, 1'b0);
        bits(1, 7'b1111111, 7);
        idle(1);
        chk("nonovl_cnt", 32'(b_cnt), 2);

        // Enable drop flushes partial history.
        set_cfg(1, 3'b111, 3'b111, 1'b1);
        bits(1, 2'b11, 2);
        idle(1);
        bits(1, 1'b1, 1);
        idle(1);
        chk("flush_cnt", 32'(b_cnt), 0);

        // Pattern input changes while enabled are ignored until en drops.
        set_cfg(1, 3'b111, 3'b111, 1'b1);
        s_pat[1] = 3'b000;
        bits(1, 3'b111, 3);
        idle(1);
        chk("cfg_hold_cnt", 32'(b_cnt), 1);
        bits(1, 3'b000, 3);
        idle(1);
        chk("cfg_reload_cnt", 32'(b_cnt), 2);

        // Saturation at 3 after six hits, then clr beats a simultaneous hit.
        set_cfg(1, 3'b111, 3'b111, 1'b1);
        bits(1, 8'hFF, 8);
        s_clr[1] = 1'b1;
        bits(1, 1'b1, 1);
        chk("sat_cnt", 32'(b_cnt), 3);
        s_clr[1] = 1'b0;
        idle(1);
        chk("clr_over_hit_cnt", 32'(b_cnt), 0);

        // Reset mid-run discards history and counter.
        set_cfg(1, 3'b111, 3'b111, 1'b1);
        bits(1, 5'b11111, 5);
        s_rst_n = 1'b0;
        bits(1, 1'b0, 1);
        s_rst_n = 1'b1;
        bits(1, 1'b1, 1);
        chk("reset_midrun_cnt", 32'(b_cnt), 0);
        idle(1);
        chk("after_reset_cnt", 32'(b_cnt), 0);
        s_pat[1] = 3'b111; s_mask[1] = 3'b111; s_ovl[1] = 1'b1;
        idle(1);
        bits(1, 3'b111, 3);
        idle(1);
        chk("after_reset_hit_cnt", 32'(b_cnt), 1);

        // PAT_W=4 masking and fill.
        set_cfg(0, 4'b1001, 4'b1001, 1'b1);
        bits(0, 4'b1001, 4);
        idle(0);
        chk("mask_1001_cnt", 32'(a_cnt), 1);
        set_cfg(0, 4'b1001, 4'b1001, 1'b1);
        bits(0, 4'b1111, 4);
        idle(0);
        chk("mask_1111_cnt", 32'(a_cnt), 1);
        set_cfg(0, 4'b0001, 4'b0001, 1'b1);
        bits(0, 1'b1, 1);
        idle(0);
        chk("lone_bit_cnt", 32'(a_cnt), 0);

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            s_rst_n = ($urandom_range(299) != 0);
            for (int i = 0; i < 2; i++) begin
                s_en[i]  = ($urandom_range(7) != 0);
                s_d[i]   = 1'($urandom_range(1));
                s_clr[i] = ($urandom_range(31) == 0);
                if (!s_en[i]) begin
                    s_pat[i]  = $urandom;
                    s_mask[i] = ($urandom_range(1) != 0) ? 32'hFFFF_FFFF : $urandom;
                    s_ovl[i]  = 1'($urandom_range(1));
                end
            end
            tick();
        end
        s_rst_n = 1'b1;
        idle(0);
        idle(1);
        @(posedge clk);
        @(posedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_seq_pattern_rec_mealy

// File: doc/seq_pattern_rec_mealy.md
# seq_pattern_rec_mealy

Parametrised Mealy sequence recogniser that flags a programmable, maskable bit pattern of up to PAT_W bits on a serial input. It supports overlapping and non-overlapping match modes and counts hits in a saturating counter. It generalises the fixed three-consecutive-ones recogniser; the legacy behaviour is the configuration PAT_W=3, pat=3'b111, mask=3'b111, overlap=1. It sits directly on the serial data path and feeds its counter to status logic.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- CNT_W, 8: width of the hit counter; legal range 1..32.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low. Only clock domain: clk.
- en  input  1  recognition enable; low flushes history.
- d_in  input  1  serial data bit, sampled each cycle en=1.
- pat  input  PAT_W  pattern; pat[PAT_W-1] is the oldest bit, pat[0] matches the current d_in.
- mask  input  PAT_W  per-bit compare enable; 0 = don't care.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- clr  input  1  synchronous clear of hit_cnt.
- d_out  output  1  Mealy hit, combinational from d_in.
- hit_cnt  output  CNT_W  saturating count of hits.

## Operation
- Config registers cfg_pat, cfg_mask, cfg_ovl:
  - load pat/mask/overlap every cycle en=0;
  - hold while en=1.
  - Mid-run config changes have no effect until en drops.
- History register hist is PAT_W-1 bits; newest bit is in hist[0]. Fill counter fill runs 0..PAT_W-1 (valid history bits).
- Match:
  - match = en & (fill==PAT_W-1) & ((({hist,d_in} ^ cfg_pat) & cfg_mask) == 0).
  - d_out = match.
  - A history-fill requirement applies even to masked bits, so the first hit is possible on the PAT_W-th enabled bit at the earliest.
- When en=1, every edge:
  - hist <= {hist[PAT_W-3:0], d_in}.
  - If match and cfg_ovl=0, fill <= 0 (history restarts from scratch).
  - Otherwise fill <= min(fill+1, PAT_W-1).
- When en=0, every edge:
  - hist <= 0 and fill <= 0.
  - d_out = 0.
  - Counter holds (clr still acts).
- Hit counter:
  - If clr=1, hit_cnt <= 0. clr wins over a simultaneous hit.
  - Else if match and hit_cnt != all-ones, hit_cnt <= hit_cnt+1.
  - All-ones saturates and holds.
- States (implicit in fill): FLUSH (fill=0), FILLING (0<fill<PAT_W-1), ARMED (fill=PAT_W-1).
  - ARMED to FLUSH: non-overlap hit, or en=0.
  - Any state to FLUSH: en=0.

## Timing
- Reset (rst_n=0 at an edge) clears hist, fill, hit_cnt, cfg_pat, cfg_mask and cfg_ovl to 0. d_out reads 0 because fill=0.
- Reset mid-run discards partial history; the next match needs PAT_W fresh enabled bits.
- d_out has zero latency: valid in the same cycle as the completing d_in. It is combinational, so d_in must settle before the edge.
- hit_cnt reflects a hit one cycle after d_out.
- en rising: the first enabled cycle uses config latched on the previous edge, i.e. the inputs seen while en was still low.
- Overlap: consecutive d_out pulses are possible every cycle.
- Non-overlap: minimum PAT_W cycles between d_out pulses.

## Structure
- Package seq_rec_pkg holds:
  - constants MODE_NONOVL=1'b0 and MODE_OVL=1'b1;
  - PAT_W_MIN=2 and PAT_W_MAX=16 for the elaboration-time parameter check.
- Sub-module sat_counter (parameter W; ports clk, rst_n, clr, inc, cnt) implements hit_cnt. It is reused by later status blocks.
- Recogniser core (hist, fill, cfg registers, match comparator) stays in seq_pattern_rec_mealy.

## Test plan
- Legacy three-ones, overlap: PAT_W=3, pat=111, mask=111, overlap=1, en=1, stream 0,1,1,1,1,0,1,1,1 -> d_out=1 on bits 4, 5 and 9 (1-based); hit_cnt ends at 3.
- Non-overlap: same pattern, overlap=0, stream 1,1,1,1,1,1,1 -> d_out=1 on bits 3 and 6 only; hit_cnt=2.
- Masking and fill, PAT_W=4:
  - pat=1001, mask=1001, stream 1,0,0,1 -> hit on bit 4.
  - Stream 1,1,1,1 -> hit on bit 4 (middle bits masked).
  - A lone 1 presented as the first enabled bit -> no hit.
- Enable flush: PAT_W=3, pattern 111, stream 1,1, en=0 for 1 cycle, 1 -> no hit. Also, changing pat while en=1 has no effect until en drops.
- Counter: CNT_W=2, overlap=1, 6 hits -> hit_cnt=3 (saturated). clr asserted in the same cycle as a hit -> hit_cnt=0 next cycle.
- Reset mid-run: PAT_W=3, stream 1,1, then rst_n=0 for one edge, then 1 -> no hit, all outputs 0. The next hit needs 1,1,1.
